uart_tx_arbiter: RTL and testbench

- Shares one UART_Tx transmitter between N requesters using round-robin arbitration.
- Latches the granted requester's word, launches it with a one-cycle NewData pulse, then waits for DoneTx.
- Counts receiver NACKs. Bounds each frame by a retry limit and a watchdog; on either limit it aborts the transmitter and returns an error.
- Sits between client logic and UART_Tx on the baud clock domain.

---
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_Tx between N requesters; counts receiver
// NACKs per frame and aborts the transmitter on retry exhaustion or watchdog expiry.
module uart_tx_arbiter #(
  parameter int N         = 4,
  parameter int SIZE      = 32,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 1024
) (
  input  logic                           CLK_Baudin,
  input  logic                           RstArb_n,
  input  logic [N-1:0]                   Req,
  input  logic [N*SIZE-1:0]              ReqData,
  output logic [N-1:0]                   Ack,
  output logic [N-1:0]                   Err,
  output logic [$clog2(N)-1:0]           GrantId,
  output logic                           Busy,
  output logic [$clog2(MAX_RETRY+2)-1:0] RetryCnt,
  output logic [SIZE-1:0]                TxDataOut,
  output logic                           TxNewData,
  output logic                           TxAbort,
  input  logic                           TxDone,
  input  logic                           FrameNack
);

  localparam int IDW = $clog2(N);
  localparam int RCW = $clog2(MAX_RETRY + 2);
  localparam int TMW = $clog2(TIMEOUT + 1);
  localparam logic [RCW-1:0] RETRY_LIMIT = RCW'(MAX_RETRY + 1);
  localparam logic [TMW-1:0] TIMER_LIMIT = TMW'(TIMEOUT);
  localparam logic [IDW-1:0] LAST_INIT   = IDW'(N - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    ABORT = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t         state_reg;
  logic [IDW-1:0] last_reg;
  logic [TMW-1:0] timer_reg;
  logic           done_prev_reg;
  logic           nack_prev_reg;

  logic [SIZE-1:0] req_word [N];
  logic            win_found;
  logic [IDW-1:0]  win_idx;
  logic [IDW-1:0]  cand;
  logic            done_rise;
  logic            nack_rise;
  logic [RCW-1:0]  retry_next;
  logic [TMW-1:0]  timer_next;
  logic [N-1:0]    grant_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_word
      assign req_word[gi] = ReqData[gi*SIZE +: SIZE];
    end
  endgenerate

  // Scan from the farthest candidate back to last+1 so the nearest set bit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IDW'((int'(last_reg) + k) % N);
      if (Req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // DoneTx stays high after a frame, so only its rising edge counts as completion.
  assign done_rise    = TxDone & ~done_prev_reg;
  assign nack_rise    = FrameNack & ~nack_prev_reg;
  assign retry_next   = (nack_rise && (RetryCnt != RETRY_LIMIT)) ? RetryCnt + RCW'(1) : RetryCnt;
  assign timer_next   = timer_reg + TMW'(1);
  assign grant_onehot = {{(N-1){1'b0}}, 1'b1} << GrantId;

  always_ff @(posedge CLK_Baudin or negedge RstArb_n) begin
    if (!RstArb_n) begin
      state_reg     <= IDLE;
      last_reg      <= LAST_INIT;
      timer_reg     <= '0;
      done_prev_reg <= 1'b0;
      nack_prev_reg <= 1'b0;
      Ack           <= '0;
      Err           <= '0;
      GrantId       <= '0;
      Busy          <= 1'b0;
      RetryCnt      <= '0;
      TxDataOut     <= '0;
      TxNewData     <= 1'b0;
      TxAbort       <= 1'b0;
    end else begin
      done_prev_reg <= TxDone;
      nack_prev_reg <= FrameNack;
      TxNewData     <= 1'b0;
      TxAbort       <= 1'b0;
      Ack           <= '0;
      Err           <= '0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            TxDataOut <= req_word[win_idx];
            GrantId   <= win_idx;
            last_reg  <= win_idx;
            RetryCnt  <= '0;
            timer_reg <= '0;
            Busy      <= 1'b1;
            TxNewData <= 1'b1;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          timer_reg <= timer_next;
          RetryCnt  <= retry_next;
          if (done_rise) begin
            Ack       <= grant_onehot;
            state_reg <= RESP;
          end else if ((retry_next == RETRY_LIMIT) || (timer_next == TIMER_LIMIT)) begin
            TxAbort   <= 1'b1;
            state_reg <= ABORT;
          end
        end
        ABORT: begin
          Err       <= grant_onehot;
          state_reg <= RESP;
        end
        RESP: begin
          Busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a table of frames plus hand-written
// reset-state and reset-mid-WAIT sequences.
module tb_uart_tx_arbiter;

  localparam int N         = 4;
  localparam int SIZE      = 32;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 64;

  logic              CLK_Baudin = 1'b0;
  logic              RstArb_n   = 1'b0;
  logic [N-1:0]      Req        = '0;
  logic [N*SIZE-1:0] ReqData    = '0;
  logic [N-1:0]      Ack;
  logic [N-1:0]      Err;
  logic [1:0]        GrantId;
  logic              Busy;
  logic [2:0]        RetryCnt;
  logic [SIZE-1:0]   TxDataOut;
  logic              TxNewData;
  logic              TxAbort;
  logic              TxDone    = 1'b0;
  logic              FrameNack = 1'b0;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .N(N), .SIZE(SIZE), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK_Baudin(CLK_Baudin),
    .RstArb_n(RstArb_n),
    .Req(Req),
    .ReqData(ReqData),
    .Ack(Ack),
    .Err(Err),
    .GrantId(GrantId),
    .Busy(Busy),
    .RetryCnt(RetryCnt),
    .TxDataOut(TxDataOut),
    .TxNewData(TxNewData),
    .TxAbort(TxAbort),
    .TxDone(TxDone),
    .FrameNack(FrameNack)
  );

  always #5 CLK_Baudin = ~CLK_Baudin;

  typedef struct {
    logic [3:0]  req;       // request bits added at frame start
    int          nacks;     // NACK pulses at WAIT cycles 2,6,10,14
    int          done_at;   // WAIT cycle where TxDone rises (0 = never)
    int          exp_gid;
    bit          exp_ok;
    int          exp_retry;
    int          exp_resp;  // WAIT-relative cycle of the Ack/Err pulse
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=no_event required=event_within_bound", name);
  endtask

  task automatic run_frame(input int fi);
    vec_t       v;
    bit         got;
    int         resp_c;
    int         abort_cnt;
    logic [3:0] mask;
    v    = vecs[fi];
    mask = 4'b0001 << v.exp_gid;
    Req       = Req | v.req;
    FrameNack = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK_Baudin);
      if (TxNewData) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      bound_fail($sformatf("f%0d_newdata", fi));
      return;
    end
    chk($sformatf("f%0d_gid", fi), 64'(GrantId), 64'(v.exp_gid));
    chk($sformatf("f%0d_data_load", fi), 64'(TxDataOut), 64'(v.exp_data));
    chk($sformatf("f%0d_busy_load", fi), 64'(Busy), 64'd1);

    resp_c    = 0;
    abort_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge CLK_Baudin);
      if (TxAbort) abort_cnt++;
      if (c == 1) chk($sformatf("f%0d_newdata_pulse", fi), 64'(TxNewData), 64'd0);
      if (Ack != 0 || Err != 0) begin
        resp_c = c;
        break;
      end
      if (c >= 2) TxDone = (v.done_at > 0) && (c >= v.done_at);
      FrameNack = ((c % 4) == 2) && ((c / 4) < v.nacks);
    end
    FrameNack = 1'b0;
    if (resp_c == 0) begin
      bound_fail($sformatf("f%0d_resp", fi));
      return;
    end
    chk($sformatf("f%0d_resp_cycle", fi), 64'(resp_c), 64'(v.exp_resp));
    chk($sformatf("f%0d_ack", fi), 64'(Ack), v.exp_ok ? 64'(mask) : 64'd0);
    chk($sformatf("f%0d_err", fi), 64'(Err), v.exp_ok ? 64'd0 : 64'(mask));
    chk($sformatf("f%0d_retry", fi), 64'(RetryCnt), 64'(v.exp_retry));
    chk($sformatf("f%0d_busy_resp", fi), 64'(Busy), 64'd1);
    chk($sformatf("f%0d_abort_cycles", fi), 64'(abort_cnt), v.exp_ok ? 64'd0 : 64'd1);
    chk($sformatf("f%0d_data_resp", fi), 64'(TxDataOut), 64'(v.exp_data));
    $display("frame %0d gid=%0d ack=%b err=%b retry=%0d resp_cycle=%0d",
             fi, GrantId, Ack, Err, RetryCnt, resp_c);
    Req[v.exp_gid] = 1'b0;
    @(negedge CLK_Baudin);
    chk($sformatf("f%0d_ack_clear", fi), 64'(Ack | Err), 64'd0);
    chk($sformatf("f%0d_busy_idle", fi), 64'(Busy), 64'd0);
  endtask

  initial begin
    bit got;
    //          req      nk done gid ok  rt resp data
    vecs[0]  = '{4'b0100, 0, 5,  2, 1'b1, 0, 6,  32'hA5A5_1234};
    vecs[1]  = '{4'b0001, 2, 9,  0, 1'b1, 2, 10, 32'h0BAD_0000};
    vecs[2]  = '{4'b0010, 4, 0,  1, 1'b0, 4, 16, 32'hC0DE_0001};
    vecs[3]  = '{4'b1000, 1, 3,  3, 1'b1, 1, 4,  32'hDEAD_0003};
    vecs[4]  = '{4'b1111, 0, 3,  0, 1'b1, 0, 4,  32'h0BAD_0000};
    vecs[5]  = '{4'b0000, 0, 4,  1, 1'b1, 0, 5,  32'hC0DE_0001};
    vecs[6]  = '{4'b0000, 0, 3,  2, 1'b1, 0, 4,  32'hA5A5_1234};
    vecs[7]  = '{4'b0000, 0, 6,  3, 1'b1, 0, 7,  32'hDEAD_0003};
    vecs[8]  = '{4'b1001, 0, 3,  0, 1'b1, 0, 4,  32'h0BAD_0000};
    vecs[9]  = '{4'b0000, 0, 3,  3, 1'b1, 0, 4,  32'hDEAD_0003};
    vecs[10] = '{4'b0100, 0, 0,  2, 1'b0, 0, 66, 32'hA5A5_1234};
    vecs[11] = '{4'b0001, 0, 64, 0, 1'b1, 0, 65, 32'h0BAD_0000};
    vecs[12] = '{4'b0010, 4, 14, 1, 1'b1, 4, 15, 32'hC0DE_0001};

    ReqData = {32'hDEAD_0003, 32'hA5A5_1234, 32'hC0DE_0001, 32'h0BAD_0000};

    // Reset state
    repeat (2) @(negedge CLK_Baudin);
    chk("rst_ack", 64'(Ack), 64'd0);
    chk("rst_err", 64'(Err), 64'd0);
    chk("rst_gid", 64'(GrantId), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_retry", 64'(RetryCnt), 64'd0);
    chk("rst_data", 64'(TxDataOut), 64'd0);
    chk("rst_newdata", 64'(TxNewData), 64'd0);
    chk("rst_abort", 64'(TxAbort), 64'd0);
    RstArb_n = 1'b1;
    repeat (2) @(negedge CLK_Baudin);
    chk("idle_busy_noreq", 64'(Busy), 64'd0);

    for (int i = 0; i < 13; i++) run_frame(i);

    // Reset mid-WAIT: grant requester 0 (pointer=0), take one NACK, then reset.
    TxDone = 1'b0;
    Req    = 4'b0001;
    got    = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK_Baudin);
      if (TxNewData) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) bound_fail("midrst_newdata");
    @(negedge CLK_Baudin);
    FrameNack = 1'b1;
    @(negedge CLK_Baudin);
    FrameNack = 1'b0;
    @(negedge CLK_Baudin);
    chk("midrst_pre_retry", 64'(RetryCnt), 64'd1);
    chk("midrst_pre_busy", 64'(Busy), 64'd1);
    #2 RstArb_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_retry", 64'(RetryCnt), 64'd0);
    chk("midrst_data", 64'(TxDataOut), 64'd0);
    chk("midrst_gid", 64'(GrantId), 64'd0);
    chk("midrst_newdata_abort", 64'({TxNewData, TxAbort}), 64'd0);
    for (int t = 0; t < 3; t++) begin
      @(negedge CLK_Baudin);
      chk($sformatf("midrst_hold_resp%0d", t), 64'(Ack | Err), 64'd0);
    end
    RstArb_n = 1'b1;
    Req      = 4'b0011;
    got      = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK_Baudin);
      if (TxNewData) begin
        got = 1'b1;
        break;
      end
      chk($sformatf("postrst_noresp%0d", t), 64'(Ack | Err), 64'd0);
    end
    if (!got) bound_fail("postrst_newdata");
    else begin
      chk("postrst_gid", 64'(GrantId), 64'd0);
      chk("postrst_data", 64'(TxDataOut), 64'h0BAD_0000);
      $display("post-reset grant gid=%0d data=%h", GrantId, TxDataOut);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
